// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider, byte type and FIFO pointer width helper.
package uart_pkg;

  localparam int BAUD_TICKS = 5208;

  typedef logic [7:0] uart_byte_t;

  // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the UART receive FIFO.
// Synchronous write port, asynchronous read port; contents are never reset.
module uart_rx_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming byte into the addressed slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with first-word fall-through valid/ready output.
// Bytes arriving while full are dropped and flagged by a sticky overflow.
// Optional feature macro: UART_RX_FIFO_DROPCNT_EN adds a saturating drop_count port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         rx_byte,
  input  logic                     rx_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef UART_RX_FIFO_DROPCNT_EN
  ,
  output logic [7:0]               drop_count
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          push;
  logic          pop;
  logic          drop;

  // Flags come straight from the registered pointers; the wrap bit tells full from empty.
  assign level     = wp - rp;
  assign out_valid = (wp != rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

  // A pop frees a slot this cycle, so a push is still accepted when full and popping.
  assign pop  = out_valid && out_ready;
  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  // Pointer registers; reset empties the FIFO and discards any byte in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        wp <= wp + PW'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
    end
  end

  // Sticky overflow flag; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROPCNT_EN
  // Saturating drop counter; a clear together with a drop leaves a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= 8'd0;
    end else if (ovf_clr) begin
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

  uart_rx_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push && !rst),
    .waddr(wp[AW-1:0]),
    .wdata(rx_byte),
    .raddr(rp[AW-1:0]),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: hand-computed vector table plus a
// queue scoreboard that tracks expected contents, occupancy and overflow.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] rx_byte;
  logic             rx_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;
  logic             full;
  logic             overflow;
  logic             ovf_clr;
`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [7:0]       drop_count;
`endif

  uart_rx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`ifdef UART_RX_FIFO_DROPCNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  // 50 MHz clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  uart_byte_t sb[$];
  logic       model_ovf;
  int         model_drops;

  typedef struct {
    logic       v;
    uart_byte_t b;
    logic       rdy;
    logic       clr;
    int         exp_level;
    logic       exp_valid;
    logic       exp_full;
    logic       exp_ovf;
    uart_byte_t exp_data;
  } vec_t;

  vec_t vecs[$];

  // Compare one value against its expectation and log a FAIL line when they differ.
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Compare all outputs with the scoreboard model after a clock edge.
  task automatic checkOutput(input string name);
    check({name, ".level"}, int'(level), sb.size());
    check({name, ".full"}, int'(full), int'(sb.size() == DEPTH));
    check({name, ".out_valid"}, int'(out_valid), int'(sb.size() != 0));
    check({name, ".overflow"}, int'(overflow), int'(model_ovf));
    if (sb.size() != 0) begin
      check({name, ".out_data"}, int'(out_data), int'(sb[0]));
    end
`ifdef UART_RX_FIFO_DROPCNT_EN
    check({name, ".drop_count"}, int'(drop_count), model_drops);
`endif
  endtask

  // Drive one cycle of inputs, update the model, clock, then check outputs.
  task automatic applyStimulus(input logic v, input uart_byte_t b, input logic rdy,
                               input logic clr, input string name);
    int sz;
    bit pop;
    bit drop;
    rx_valid  = v;
    rx_byte   = b;
    out_ready = rdy;
    ovf_clr   = clr;
    sz   = sb.size();
    pop  = (sz != 0) && rdy;
    drop = v && (sz == DEPTH) && !pop;
    if (pop) begin
      check({name, ".pop_data"}, int'(out_data), int'(sb[0]));
      void'(sb.pop_front());
    end
    if (v && !drop) begin
      sb.push_back(b);
    end
    if (drop) begin
      model_ovf = 1'b1;
    end else if (clr) begin
      model_ovf = 1'b0;
    end
    if (clr) begin
      model_drops = drop ? 1 : 0;
    end else if (drop && model_drops < 255) begin
      model_drops++;
    end
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  // Reset cycle, optionally with a receiver strobe that must be discarded.
  task automatic doReset(input logic v, input string name);
    rst       = 1'b1;
    rx_valid  = v;
    rx_byte   = 8'hEE;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    rx_valid    = 1'b0;
    sb.delete();
    model_ovf   = 1'b0;
    model_drops = 0;
    checkOutput(name);
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_byte   = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_ovf   = 1'b0;
    model_drops = 0;
    @(posedge clk);
    doReset(1'b0, "reset");

    // Hand-computed vectors from an empty FIFO: single byte, FWFT, empty-pop cases.
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h3C});
    vecs.push_back('{1'b1, 8'h4D, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h4D});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h11});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].b, vecs[i].rdy, vecs[i].clr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tlevel", i), int'(level), vecs[i].exp_level);
      check($sformatf("vec%0d.tvalid", i), int'(out_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d.tfull", i), int'(full), int'(vecs[i].exp_full));
      check($sformatf("vec%0d.tovf", i), int'(overflow), int'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d.tdata", i), int'(out_data), int'(vecs[i].exp_data));
      end
    end

    // Fill with 0x00..0x0F while the consumer stalls.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, uart_byte_t'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
    end
    check("fill.full_const", int'(full), 1);
    check("fill.level_const", int'(level), DEPTH);

    // Drop while full, then a drop coinciding with a clear keeps overflow set.
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, "drop1");
    check("drop1.ovf_const", int'(overflow), 1);
    check("drop1.head_const", int'(out_data), 8'h00);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b1, "drop_clr");
    check("drop_clr.ovf_const", int'(overflow), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "clr");
    check("clr.ovf_const", int'(overflow), 0);

    // Full with simultaneous push and pop: accepted, no overflow, 0x77 last.
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, "full_pp");
    check("full_pp.ovf_const", int'(overflow), 0);
    check("full_pp.level_const", int'(level), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("drain%0d", i));
    end
    check("drain.empty_const", int'(out_valid), 0);

    // Streaming across pointer wraps at one push and one pop per cycle.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, uart_byte_t'(8'h80 + i), 1'b1, 1'b0, $sformatf("wrap%0d", i));
      check($sformatf("wrap%0d.level_le1", i), int'(level <= 1), 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "wrap_end");
    check("wrap_end.ovf_const", int'(overflow), 0);

    // Build level=5 with overflow set, then reset together with rx_valid.
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b1, uart_byte_t'(8'hC0 + i), 1'b0, 1'b0, $sformatf("prep%0d", i));
    end
    for (int i = 0; i < DEPTH - 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("trim%0d", i));
    end
    check("pre_rst.level_const", int'(level), 5);
    check("pre_rst.ovf_const", int'(overflow), 1);
    doReset(1'b1, "rst_mid");
    check("rst_mid.level_const", int'(level), 0);
    check("rst_mid.valid_const", int'(out_valid), 0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, "post_rst");
    check("post_rst.data_const", int'(out_data), 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
